// File: rtl/store_ctrl_pkg.sv
// Shared constants and types for the RV32I store read-modify-write controller.
// Store widths, FSM state encoding, fault codes and small address helpers.
package store_ctrl_pkg;

  localparam logic [2:0] F3_SB = 3'h0;
  localparam logic [2:0] F3_SH = 3'h1;
  localparam logic [2:0] F3_SW = 3'h2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_FUNCT3   = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Only called for legal widths; SB can never be misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    return ((funct3 == F3_SH) && lane[0]) || ((funct3 == F3_SW) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational store data merge: inserts the byte/halfword of rs2 into the
// addressed lane of an existing memory word; SW replaces the whole word.
module store_lane_merge
  import store_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] rs2,
  output logic [31:0] merged
);

  // NOTE: merged gets a full default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    merged = old_word;
    case (funct3)
      F3_SB: begin
        case (lane)
          2'd0:    merged[7:0]   = rs2[7:0];
          2'd1:    merged[15:8]  = rs2[7:0];
          2'd2:    merged[23:16] = rs2[7:0];
          default: merged[31:24] = rs2[7:0];
        endcase
      end
      F3_SH: begin
        if (lane[1]) merged[31:16] = rs2[15:0];
        else         merged[15:0]  = rs2[15:0];
      end
      F3_SW:   merged = rs2;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store sequencing controller: SW as a single write, SB/SH as read-merge-write
// against a word-addressed data memory, with alignment checks and ack timeout.
module store_rmw_ctrl
  import store_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_r_op,
  output logic [31:0] mem_r_addr,
  input  logic        mem_r_ack,
  input  logic [31:0] mem_r_val,
  output logic        mem_w_op,
  output logic [31:0] mem_w_mem_addr,
  output logic [31:0] mem_w_mem_val,
  input  logic        mem_w_ack,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        r_op_d, w_op_d, done_d, err_d;
  logic [31:0] r_addr_d, w_addr_d, w_val_d;
  err_code_e   code_d;
  logic [31:0] merged;
  logic        timeout_hit;

  assign req_ready   = (state_q == ST_IDLE);
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  store_lane_merge u_merge (
    .funct3   (f3_q),
    .lane     (lane_q),
    .old_word (mem_r_val),
    .rs2      (data_q),
    .merged   (merged)
  );

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    lane_d   = lane_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    r_op_d   = mem_r_op;
    r_addr_d = mem_r_addr;
    w_op_d   = mem_w_op;
    w_addr_d = mem_w_mem_addr;
    w_val_d  = mem_w_mem_val;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          f3_d   = req_funct3;
          lane_d = req_addr[1:0];
          data_d = req_data;
          cnt_d  = '0;
          if (req_funct3 > F3_SW) begin
            err_d  = 1'b1;
            code_d = ERR_FUNCT3;
          end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
            err_d  = 1'b1;
            code_d = ERR_MISALIGN;
          end else if (req_funct3 == F3_SW) begin
            state_d  = ST_WRITE;
            w_op_d   = 1'b1;
            w_addr_d = word_align(req_addr);
            w_val_d  = req_data;
          end else begin
            // Write address is fixed now; only the data waits for the read.
            state_d  = ST_READ;
            r_op_d   = 1'b1;
            r_addr_d = word_align(req_addr);
            w_addr_d = word_align(req_addr);
          end
        end
      end

      ST_READ: begin
        if (mem_r_ack) begin
          state_d = ST_WRITE;
          r_op_d  = 1'b0;
          w_op_d  = 1'b1;
          w_val_d = merged;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          r_op_d  = 1'b0;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WRITE: begin
        if (mem_w_ack) begin
          state_d = ST_IDLE;
          w_op_d  = 1'b0;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          w_op_d  = 1'b0;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      f3_q           <= '0;
      lane_q         <= '0;
      data_q         <= '0;
      cnt_q          <= '0;
      mem_r_op       <= 1'b0;
      mem_r_addr     <= '0;
      mem_w_op       <= 1'b0;
      mem_w_mem_addr <= '0;
      mem_w_mem_val  <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      err_code       <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      f3_q           <= f3_d;
      lane_q         <= lane_d;
      data_q         <= data_d;
      cnt_q          <= cnt_d;
      mem_r_op       <= r_op_d;
      mem_r_addr     <= r_addr_d;
      mem_w_op       <= w_op_d;
      mem_w_mem_addr <= w_addr_d;
      mem_w_mem_val  <= w_val_d;
      done           <= done_d;
      err            <= err_d;
      err_code       <= code_d;
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Self-checking bench for store_rmw_ctrl: directed scenarios plus randomized
// stores checked against a byte-mask reference model.
module tb_store_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_data;
  logic        mem_r_op, mem_r_ack;
  logic [31:0] mem_r_addr, mem_r_val;
  logic        mem_w_op, mem_w_ack;
  logic [31:0] mem_w_mem_addr, mem_w_mem_val;
  logic        done, err;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_rmw_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .mem_r_op       (mem_r_op),
    .mem_r_addr     (mem_r_addr),
    .mem_r_ack      (mem_r_ack),
    .mem_r_val      (mem_r_val),
    .mem_w_op       (mem_w_op),
    .mem_w_mem_addr (mem_w_mem_addr),
    .mem_w_mem_val  (mem_w_mem_val),
    .mem_w_ack      (mem_w_ack),
    .done           (done),
    .err            (err),
    .err_code       (err_code)
  );

  typedef struct {
    int          r_cycles, w_cycles, done_cnt, err_cnt, done_cyc, err_cyc;
    logic [1:0]  code;
    logic [31:0] r_addr, w_addr, w_val;
    bit          r_unstable, w_unstable, overlap, code_stray, both_pulse;
    bit          finished, ready_at_issue;
  } obs_t;

  // Reference model: error class from the store rules.
  function automatic int model_err(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 > 3'd2) return 2;
    if ((f3 == 3'd1 && (addr % 2) != 0) || (f3 == 3'd2 && (addr % 4) != 0)) return 1;
    return 0;
  endfunction

  // Reference model: word written to memory, via a shifted byte mask.
  function automatic logic [31:0] model_word(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] data, input logic [31:0] old);
    int sh;
    logic [31:0] m;
    if (f3 == 3'd2) return data;
    if (f3 == 3'd0) begin
      sh = 8 * int'(addr % 4);
      m  = 32'hFF << sh;
    end else begin
      sh = 16 * int'((addr / 2) % 2);
      m  = 32'hFFFF << sh;
    end
    return (old & ~m) | ((data << sh) & m);
  endfunction

  // Drives one request and a memory responder; ack lat<0 means never ack.
  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rval, input int r_lat, input int w_lat, output obs_t o);
    int tail;
    o = '{default: 0};
    tail = -1;
    @(negedge clk);
    o.ready_at_issue = req_ready;
    req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_data = data;
    mem_r_val = rval; mem_r_ack = 1'b0; mem_w_ack = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0; req_funct3 = 3'($urandom); req_addr = $urandom; req_data = $urandom;
      mem_r_ack = 1'b0; mem_w_ack = 1'b0;
      if (mem_r_op && mem_w_op) o.overlap = 1;
      if (mem_r_op) begin
        if (o.r_cycles == 0) o.r_addr = mem_r_addr;
        else if (mem_r_addr !== o.r_addr) o.r_unstable = 1;
        o.r_cycles++;
        if (r_lat >= 0 && o.r_cycles == r_lat + 1) mem_r_ack = 1'b1;
      end
      if (mem_w_op) begin
        if (o.w_cycles == 0) begin
          o.w_addr = mem_w_mem_addr; o.w_val = mem_w_mem_val;
        end else if (mem_w_mem_addr !== o.w_addr || mem_w_mem_val !== o.w_val) o.w_unstable = 1;
        o.w_cycles++;
        if (w_lat >= 0 && o.w_cycles == w_lat + 1) mem_w_ack = 1'b1;
      end
      if (done && err) o.both_pulse = 1;
      if (err !== 1'b1 && err_code !== 2'd0) o.code_stray = 1;
      if (done) begin o.done_cnt++; if (o.done_cyc == 0) o.done_cyc = cyc; end
      if (err) begin o.err_cnt++; o.code = err_code; if (o.err_cyc == 0) o.err_cyc = cyc; end
      if (tail < 0 && (done || err)) tail = 2;
      else if (tail > 0) tail--;
      if (tail == 0) begin o.finished = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_data = 32'h1;
    mem_r_ack = 1'b1; mem_w_ack = 1'b1; mem_r_val = 32'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_r_op, mem_w_op, done, err, err_code} !== 6'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ctrl got=%b ready=%b exp=000000 ready=1",
                      {mem_r_op, mem_w_op, done, err, err_code}, req_ready);
    end
    total++;
    if ({mem_r_addr, mem_w_mem_addr, mem_w_mem_val} !== 96'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {mem_r_addr, mem_w_mem_addr, mem_w_mem_val});
    end
    rst = 1'b0; req_valid = 1'b0; mem_r_ack = 1'b0; mem_w_ack = 1'b0;
  endtask

  task automatic test_sw();
    obs_t o;
    do_store(3'd2, 32'h0000_1004, 32'hDEADBEEF, 32'h0, 0, 0, o);
    total++;
    if (o.finished !== 1 || o.done_cnt !== 1 || o.err_cnt !== 0) begin
      bad++; $display("FAIL sw_done got done=%0d err=%0d fin=%0d exp=1/0/1", o.done_cnt, o.err_cnt, o.finished);
    end
    total++;
    if (o.r_cycles !== 0 || o.w_addr !== 32'h1004 || o.w_val !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sw_write got reads=%0d addr=%h val=%h exp=0 00001004 deadbeef", o.r_cycles, o.w_addr, o.w_val);
    end
    total++;
    if (o.done_cyc !== 2 || o.ready_at_issue !== 1) begin
      bad++; $display("FAIL sw_latency got=%0d exp=2", o.done_cyc);
    end
  endtask

  task automatic test_sb();
    obs_t o;
    do_store(3'd0, 32'h0000_2003, 32'h0000_00AA, 32'h11223344, 0, 0, o);
    total++;
    if (o.r_addr !== 32'h2000 || o.r_cycles !== 1) begin
      bad++; $display("FAIL sb_read got addr=%h cyc=%0d exp=00002000 1", o.r_addr, o.r_cycles);
    end
    total++;
    if (o.w_addr !== 32'h2000 || o.w_val !== 32'hAA223344) begin
      bad++; $display("FAIL sb_write got addr=%h val=%h exp=00002000 aa223344", o.w_addr, o.w_val);
    end
    total++;
    if (o.done_cyc !== 3 || o.done_cnt !== 1 || o.overlap) begin
      bad++; $display("FAIL sb_latency got=%0d cnt=%0d ovl=%0d exp=3 1 0", o.done_cyc, o.done_cnt, o.overlap);
    end
  endtask

  task automatic test_sh_delayed();
    obs_t o;
    do_store(3'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h11223344, 4, 0, o);
    total++;
    if (o.r_cycles !== 5 || o.r_unstable || o.r_addr !== 32'h2000) begin
      bad++; $display("FAIL sh_read_hold got cyc=%0d unst=%0d addr=%h exp=5 0 00002000", o.r_cycles, o.r_unstable, o.r_addr);
    end
    total++;
    if (o.w_val !== 32'hBEEF3344 || o.done_cnt !== 1 || o.done_cyc !== 7) begin
      bad++; $display("FAIL sh_write got val=%h done=%0d at %0d exp=beef3344 1 at 7", o.w_val, o.done_cnt, o.done_cyc);
    end
  endtask

  task automatic test_faults();
    obs_t o;
    do_store(3'd1, 32'h0000_2001, 32'h1234, 32'h0, 0, 0, o);
    total++;
    if (o.err_cnt !== 1 || o.code !== 2'd1 || o.err_cyc !== 1 || o.done_cnt !== 0) begin
      bad++; $display("FAIL misalign_err got n=%0d code=%0d at %0d done=%0d exp=1 1 at 1 0", o.err_cnt, o.code, o.err_cyc, o.done_cnt);
    end
    total++;
    if (o.r_cycles !== 0 || o.w_cycles !== 0 || o.code_stray) begin
      bad++; $display("FAIL misalign_noop got r=%0d w=%0d stray=%0d exp=0 0 0", o.r_cycles, o.w_cycles, o.code_stray);
    end
    do_store(3'd3, 32'h0000_3000, 32'h1234, 32'h0, 0, 0, o);
    total++;
    if (o.err_cnt !== 1 || o.code !== 2'd2 || o.err_cyc !== 1) begin
      bad++; $display("FAIL funct3_err got n=%0d code=%0d at %0d exp=1 2 at 1", o.err_cnt, o.code, o.err_cyc);
    end
    total++;
    if (o.r_cycles !== 0 || o.w_cycles !== 0 || o.code_stray) begin
      bad++; $display("FAIL funct3_noop got r=%0d w=%0d stray=%0d exp=0 0 0", o.r_cycles, o.w_cycles, o.code_stray);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    do_store(3'd0, 32'h0000_4001, 32'h55, 32'h0, -1, 0, o);
    total++;
    if (o.err_cnt !== 1 || o.code !== 2'd3 || o.err_cyc !== 9) begin
      bad++; $display("FAIL timeout_err got n=%0d code=%0d at %0d exp=1 3 at 9", o.err_cnt, o.code, o.err_cyc);
    end
    total++;
    if (o.r_cycles !== 8 || o.w_cycles !== 0 || o.done_cnt !== 0) begin
      bad++; $display("FAIL timeout_ops got r=%0d w=%0d done=%0d exp=8 0 0", o.r_cycles, o.w_cycles, o.done_cnt);
    end
    do_store(3'd0, 32'h0000_4001, 32'h55, 32'hFFFF_FFFF, 7, 0, o);
    total++;
    if (o.err_cnt !== 0 || o.done_cnt !== 1 || o.done_cyc !== 10 || o.w_val !== 32'hFFFF55FF) begin
      bad++; $display("FAIL timeout_ack_wins got err=%0d done=%0d at %0d val=%h exp=0 1 at 10 ffff55ff",
                      o.err_cnt, o.done_cnt, o.done_cyc, o.w_val);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'd2; req_addr = 32'h500; req_data = 32'h0BAD_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (mem_w_op !== 1'b1) begin bad++; $display("FAIL rst_pre_write got=%b exp=1", mem_w_op); end
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({mem_r_op, mem_w_op, done, err, err_code} !== 6'b0 || req_ready !== 1'b1 ||
        {mem_r_addr, mem_w_mem_addr, mem_w_mem_val} !== 96'h0) begin
      bad++; $display("FAIL rst_mid_write got ctrl=%b ready=%b data=%h exp=0 1 0",
                      {mem_r_op, mem_w_op, done, err, err_code}, req_ready, {mem_r_addr, mem_w_mem_addr, mem_w_mem_val});
    end
    req_valid = 1'b1; req_funct3 = 3'd2; req_addr = 32'h600; req_data = 32'h1111_2222;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (mem_w_op !== 1'b1 || mem_w_mem_addr !== 32'h600 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_first_write got op=%b addr=%h done=%b exp=1 00000600 0", mem_w_op, mem_w_mem_addr, done);
    end
    mem_w_ack = 1'b1;
    @(negedge clk);
    mem_w_ack = 1'b0;
    total++;
    if (done !== 1'b1 || req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_first_done got done=%b ready=%b exp=1 1", done, req_ready);
    end
    req_valid = 1'b1; req_funct3 = 3'd2; req_addr = 32'h604; req_data = 32'h3333_4444;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (mem_w_op !== 1'b1 || mem_w_mem_addr !== 32'h604 || mem_w_mem_val !== 32'h3333_4444 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_second_write got op=%b addr=%h val=%h done=%b exp=1 00000604 33334444 0",
                      mem_w_op, mem_w_mem_addr, mem_w_mem_val, done);
    end
    mem_w_ack = 1'b1;
    @(negedge clk);
    mem_w_ack = 1'b0;
    total++;
    if (done !== 1'b1 || err !== 1'b0 || mem_w_op !== 1'b0) begin
      bad++; $display("FAIL b2b_second_done got done=%b err=%b op=%b exp=1 0 0", done, err, mem_w_op);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0]  f3;
    logic [31:0] addr, data, rval;
    int          rl, wl, e, exp_cyc;
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 4));
      if (f3 == 3'd4) f3 = 3'($urandom_range(3, 7));
      addr = $urandom; data = $urandom; rval = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3 == 3'd1) addr[0] = 1'b0;
        if (f3 == 3'd2) addr[1:0] = 2'b00;
      end
      rl = $urandom_range(0, 3); wl = $urandom_range(0, 3);
      do_store(f3, addr, data, rval, rl, wl, o);
      e = model_err(f3, addr);
      total++;
      if (o.finished !== 1 || o.both_pulse || o.code_stray || o.overlap) begin
        bad++; $display("FAIL rnd_protocol n=%0d fin=%0d both=%0d stray=%0d ovl=%0d exp=1 0 0 0",
                        n, o.finished, o.both_pulse, o.code_stray, o.overlap);
      end
      if (e != 0) begin
        total++;
        if (o.err_cnt !== 1 || int'(o.code) !== e || o.done_cnt !== 0 || o.r_cycles + o.w_cycles !== 0) begin
          bad++; $display("FAIL rnd_fault n=%0d f3=%0d addr=%h got err=%0d code=%0d done=%0d exp=1 %0d 0",
                          n, f3, addr, o.err_cnt, o.code, o.done_cnt, e);
        end
      end else begin
        exp_cyc = (f3 == 3'd2) ? (wl + 2) : (rl + wl + 3);
        total++;
        if (o.done_cnt !== 1 || o.err_cnt !== 0 || o.done_cyc !== exp_cyc ||
            o.r_cycles !== ((f3 == 3'd2) ? 0 : rl + 1)) begin
          bad++; $display("FAIL rnd_timing n=%0d f3=%0d got done=%0d at %0d reads=%0d exp=1 at %0d",
                          n, f3, o.done_cnt, o.done_cyc, o.r_cycles, exp_cyc);
        end
        total++;
        if (o.w_addr !== (addr & 32'hFFFF_FFFC) || o.w_val !== model_word(f3, addr, data, rval) ||
            o.w_unstable || o.r_unstable) begin
          bad++; $display("FAIL rnd_write n=%0d f3=%0d addr=%h got %h/%h exp %h/%h", n, f3, addr,
                          o.w_addr, o.w_val, addr & 32'hFFFF_FFFC, model_word(f3, addr, data, rval));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_sh_delayed();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
Sequencing controller for RV32I store instructions (funct3 0/1/2) against a 32-bit word-addressed data memory port. It accepts one store request at a time and handles alignment checks. For SB/SH it runs a read-modify-write: read the aligned word, merge the byte or halfword lane, write it back. SW is issued as a single write. It sits between the execute stage's store decode and the shared data-memory read/write ports, and reports completion or a fault to the pipeline control.

Parameters:
TIMEOUT_CYCLES, 256, max cycles a memory op may wait for ack before abort; 0 disables timeout
CNT_W, 16, width of timeout counter; TIMEOUT_CYCLES must be < 2**CNT_W

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  store request present
req_ready  out  1  high iff FSM in IDLE; handshake fires on req_valid & req_ready
req_funct3  in  3  store width: 0=SB, 1=SH, 2=SW, others illegal
req_addr  in  32  effective byte address (rs1 + imm)
req_data  in  32  rs2 value
mem_r_op  out  1  read request, held until mem_r_ack
mem_r_addr  out  32  word-aligned read address
mem_r_ack  in  1  read data valid this cycle
mem_r_val  in  32  read data, sampled when mem_r_ack=1
mem_w_op  out  1  write request, held until mem_w_ack
mem_w_mem_addr  out  32  word-aligned write address
mem_w_mem_val  out  32  merged write data
mem_w_ack  in  1  write accepted this cycle
done  out  1  one-cycle pulse: store committed
err  out  1  one-cycle pulse: store aborted, no write performed
err_code  out  2  valid with err: 1=misaligned, 2=illegal funct3, 3=timeout; 0 otherwise

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE. All outputs 0 except req_ready=1. Counter 0 and captured regs 0. Any in-flight op is dropped with no done/err.
- All outputs are registered, except req_ready, which is decoded from state.
- States: IDLE, READ, WRITE.
- IDLE, on handshake: latch funct3, addr, data. Aligned addr = {addr[31:2],2'b00}. Checks in priority order:
  - funct3 > 2: err=1, code=2 next cycle; stay IDLE.
  - SH with addr[0]=1, or SW with addr[1:0]!=0: err=1, code=1 next cycle; stay IDLE.
  - SB/SH OK: go to READ; mem_r_op=1 next cycle.
  - SW OK: go to WRITE; mem_w_op=1 and mem_w_mem_val=req_data next cycle.
- READ: hold mem_r_op/mem_r_addr stable.
  - On mem_r_ack: merge and go to WRITE (mem_r_op=0, mem_w_op=1 next cycle).
  - SB merge: replace byte lane addr[1:0] of mem_r_val with data[7:0].
  - SH merge: replace halfword lane addr[1] with data[15:0].
  - Other lanes are preserved.
- WRITE: hold mem_w_op/addr/val stable. On mem_w_ack: next cycle mem_w_op=0, done=1, state IDLE.
- mem_r_op and mem_w_op are never high together.
- Timeout:
  - Counter clears on entering READ/WRITE and increments each cycle there without ack.
  - If TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1 with no ack: next cycle op=0, err=1, code=3, IDLE.
  - Ack in that same cycle wins; no timeout.
- done/err are high for exactly one cycle and never together. err_code returns to 0 with err.
- Back-to-back: req_ready is 1 in the cycle done/err pulses, so a new request may be accepted then.
- Minimum latency, accept edge to done: SW = 2 cycles; SB/SH = 3 cycles (ack in first asserted cycle).
- Inputs other than ack/val are ignored outside IDLE.

Decomposition:
- Package store_ctrl_pkg holds:
  - funct3 constants F3_SB=3'h0, F3_SH=3'h1, F3_SW=3'h2
  - state encoding (2-bit IDLE/READ/WRITE)
  - error codes ERR_NONE/ERR_MISALIGN/ERR_FUNCT3/ERR_TIMEOUT
- One sub-module, store_lane_merge: combinational funct3 + addr[1:0] + old word + rs2 -> merged word. Shared with any future AMO/store path.

Test Plan:
- SW addr=0x0000_1004 data=0xDEADBEEF, w_ack in first cycle: no read issued; mem_w_mem_addr=0x1004, val=0xDEADBEEF; done 2 cycles after accept.
- SB addr=0x0000_2003 data=0x000000AA, r_val=0x11223344, acks immediate: read at 0x2000; write 0xAA223344 at 0x2000; done 3 cycles after accept.
- SH addr=0x2002 data=0x0000BEEF, r_val=0x11223344, r_ack delayed 4 cycles: mem_r_op held 5 cycles with stable addr; write 0xBEEF3344; single done.
- Faults:
  - SH addr=0x2001: err=1, code=1.
  - funct3=3: err=1, code=2.
  - In both cases, no mem_r_op/mem_w_op ever asserted.
- TIMEOUT_CYCLES=8, SB with no r_ack: err=1, code=3 on the 9th cycle after READ entry. Then repeat with ack on cycle 8: no err, write proceeds.
- rst asserted mid-WRITE: next cycle all outputs 0, req_ready=1, no done. A subsequent SW completes normally back-to-back with a request accepted on the done cycle.
